// File: rtl/matriz_pkg.sv
// Shared definitions for the matrix ALU: default geometry, opcodes, FSM state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package matriz_pkg;

  localparam int N_DEF = 5;  // default matrix dimension
  localparam int W_DEF = 8;  // default element width (signed)

  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_TRN  = 4'b0110;  // transpose of A
  localparam logic [3:0] OP_OPO  = 4'b0111;  // oposta, -A
  localparam logic [3:0] OP_ESC  = 4'b1000;  // scalar times A
  localparam logic [3:0] OP_DET2 = 4'b1001;  // det of top-left 2x2 of A
  localparam logic [3:0] OP_DET3 = 4'b1010;  // det of top-left 3x3 of A

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIM  = 2'd2
  } state_t;

endpackage

// File: rtl/matriz_alu_param_if.sv
// Request/result bundle between a requester (master) and the matrix ALU (slave).
// Latency: n/a (wires only).
// Backpressure: level start held by master; done held by slave until start drops.
// Ports: opcode, data_escalar, matrizA, matrizB, start (master->slave);
//        matriz_resultante, done, erro (slave->master). Element (i,j) at [(i*N+j)*W +: W].
interface matriz_alu_param_if
  import matriz_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);
  logic [3:0]       opcode;
  logic [W-1:0]     data_escalar;
  logic [N*N*W-1:0] matrizA;
  logic [N*N*W-1:0] matrizB;
  logic             start;
  logic [N*N*W-1:0] matriz_resultante;
  logic             done;
  logic             erro;

  modport master (
    output opcode, data_escalar, matrizA, matrizB, start,
    input  matriz_resultante, done, erro
  );

  modport slave (
    input  opcode, data_escalar, matrizA, matrizB, start,
    output matriz_resultante, done, erro
  );
endinterface

// File: rtl/matriz_dot.sv
// Signed N-term dot product of a row of A and a column of B, purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: row_a, col_b (N packed W-bit signed terms, term k at [k*W +: W]);
//        dot_sum (full-precision sum, 2W+clog2(N) bits signed).
module matriz_dot
  import matriz_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic        [N*W-1:0]              row_a,
  input  logic        [N*W-1:0]              col_b,
  output logic signed [2*W+$clog2(N)-1:0]    dot_sum
);
  localparam int AW = 2*W + $clog2(N);

  logic signed [W-1:0]   a_k;
  logic signed [W-1:0]   b_k;
  logic signed [2*W-1:0] p_k;

  always_comb begin
    dot_sum = '0;
    a_k     = '0;
    b_k     = '0;
    p_k     = '0;
    for (int k = 0; k < N; k++) begin
      a_k = row_a[k*W +: W];
      b_k = col_b[k*W +: W];
      p_k = a_k * b_k;
      // sign-extend each 2W-bit product into the accumulator width
      dot_sum = dot_sum + {{(AW-2*W){p_k[2*W-1]}}, p_k};
    end
  end
endmodule

// File: rtl/matriz_alu_param.sv
// NxN signed matrix ALU: add/sub/mul/transpose/negate/scale/det2/det3 on latched operands.
// Latency: 1 CALC cycle element-wise/det2/illegal, 2 for det3, N*N for mul; done on FIM entry.
// Backpressure: level start; done held while start stays high, FIM->IDLE once start is low.
// Ports: clk, rst (sync, active-high), bus (slave modport of matriz_alu_param_if).
// Build option: define MATRIZ_ALU_SAT_EN for saturating results, otherwise results wrap.
module matriz_alu_param
  import matriz_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  matriz_alu_param_if.slave bus
);
  localparam int MW = N*N*W;
  localparam int RW = N*W;
  localparam int CW = $clog2(N);
  localparam int AW = 2*W + CW;
  // wide enough for a sum of three W*W*W products without overflow
  localparam int XW = 3*W + 4;

`ifdef MATRIZ_ALU_SAT_EN
  localparam logic signed [XW-1:0] MAXV = {{(XW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {{(XW-W+1){1'b1}}, {(W-1){1'b0}}};
`endif

  function automatic logic signed [XW-1:0] sx(input logic [W-1:0] v);
    return {{(XW-W){v[W-1]}}, v};
  endfunction

  // out-of-range indices read as 0 so det3 stays well-defined when N=2
  function automatic logic [W-1:0] el(input logic [MW-1:0] m, input int i, input int j);
    if (i >= N || j >= N) return '0;
    return m[(i*N+j)*W +: W];
  endfunction

  function automatic logic [W-1:0] reduce(input logic signed [XW-1:0] v);
`ifdef MATRIZ_ALU_SAT_EN
    if (v > MAXV)      return MAXV[W-1:0];
    else if (v < MINV) return MINV[W-1:0];
    else               return v[W-1:0];
`else
    return v[W-1:0];
`endif
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [W-1:0]    k_q, k_d;
  logic [MW-1:0]   a_q, a_d;
  logic [MW-1:0]   b_q, b_d;
  logic [MW-1:0]   res_q, res_d;
  logic            done_q, done_d;
  logic            erro_q, erro_d;
  logic [CW-1:0]   i_q, i_d;
  logic [CW-1:0]   j_q, j_d;
  logic signed [XW-1:0] p3_q, p3_d;  // det3 positive-diagonal sum from phase 0

  // ---- mul datapath: row i_q of A against column j_q of B
  logic [RW-1:0]        row_a;
  logic [RW-1:0]        col_b;
  logic signed [AW-1:0] dot_sum;

  always_comb begin
    row_a = a_q[int'(i_q)*RW +: RW];
    col_b = '0;
    for (int k = 0; k < N; k++) begin
      col_b[k*W +: W] = el(b_q, k, int'(j_q));
    end
  end

  matriz_dot #(.N(N), .W(W)) u_dot (
    .row_a   (row_a),
    .col_b   (col_b),
    .dot_sum (dot_sum)
  );

  // ---- element-wise results for all single-cycle matrix ops
  logic [MW-1:0]        ew;
  logic signed [XW-1:0] ew_v;

  always_comb begin
    ew   = '0;
    ew_v = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (op_q)
          OP_ADD:  ew_v = sx(el(a_q, i, j)) + sx(el(b_q, i, j));
          OP_SUB:  ew_v = sx(el(a_q, i, j)) - sx(el(b_q, i, j));
          OP_TRN:  ew_v = sx(el(a_q, j, i));
          OP_OPO:  ew_v = -sx(el(a_q, i, j));
          OP_ESC:  ew_v = sx(k_q) * sx(el(a_q, i, j));
          default: ew_v = '0;
        endcase
        ew[(i*N+j)*W +: W] = reduce(ew_v);
      end
    end
  end

  // ---- determinant terms (top-left corner of A)
  logic signed [XW-1:0] a00, a01, a02, a10, a11, a12, a20, a21, a22;
  logic signed [XW-1:0] det2_v, pos3_v, neg3_v;

  always_comb begin
    a00 = sx(el(a_q, 0, 0)); a01 = sx(el(a_q, 0, 1)); a02 = sx(el(a_q, 0, 2));
    a10 = sx(el(a_q, 1, 0)); a11 = sx(el(a_q, 1, 1)); a12 = sx(el(a_q, 1, 2));
    a20 = sx(el(a_q, 2, 0)); a21 = sx(el(a_q, 2, 1)); a22 = sx(el(a_q, 2, 2));
    det2_v = a00*a11 - a01*a10;
    pos3_v = a00*a11*a22 + a01*a12*a20 + a02*a10*a21;
    neg3_v = a02*a11*a20 + a00*a12*a21 + a01*a10*a22;
  end

  // ---- next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    done_d  = done_q;
    erro_d  = erro_q;
    i_d     = i_q;
    j_d     = j_q;
    p3_d    = p3_q;

    case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (bus.start) begin
          state_d = ST_CALC;
          op_d    = bus.opcode;
          k_d     = bus.data_escalar;
          a_d     = bus.matrizA;
          b_d     = bus.matrizB;
          erro_d  = 1'b0;
          i_d     = '0;
          j_d     = '0;
        end
      end

      ST_CALC: begin
        case (op_q)
          OP_ADD, OP_SUB, OP_TRN, OP_OPO, OP_ESC: begin
            res_d   = ew;
            state_d = ST_FIM;
            done_d  = 1'b1;
          end
          OP_MUL: begin
            res_d[(int'(i_q)*N + int'(j_q))*W +: W] =
              reduce({{(XW-AW){dot_sum[AW-1]}}, dot_sum});
            if (j_q == CW'(N-1)) begin
              j_d = '0;
              if (i_q == CW'(N-1)) begin
                i_d     = '0;
                state_d = ST_FIM;
                done_d  = 1'b1;
              end else begin
                i_d = i_q + CW'(1);
              end
            end else begin
              j_d = j_q + CW'(1);
            end
          end
          OP_DET2: begin
            res_d          = '0;
            res_d[W-1:0]   = reduce(det2_v);
            state_d        = ST_FIM;
            done_d         = 1'b1;
          end
          OP_DET3: begin
            // j_q doubles as the phase: 0 = latch positive sum, 1 = subtract
            if (j_q == '0) begin
              p3_d = pos3_v;
              j_d  = CW'(1);
            end else begin
              res_d        = '0;
              res_d[W-1:0] = reduce(p3_q - neg3_v);
              j_d          = '0;
              state_d      = ST_FIM;
              done_d       = 1'b1;
            end
          end
          default: begin
            res_d   = '0;
            erro_d  = 1'b1;
            state_d = ST_FIM;
            done_d  = 1'b1;
          end
        endcase
      end

      ST_FIM: begin
        if (!bus.start) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      erro_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      p3_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      done_q  <= done_d;
      erro_q  <= erro_d;
      i_q     <= i_d;
      j_q     <= j_d;
      p3_q    <= p3_d;
    end
  end

  assign bus.matriz_resultante = res_q;
  assign bus.done              = done_q;
  assign bus.erro              = erro_q;

endmodule
